// File: rtl/jtframe_frame_trig.sv
// Frame counter and dump-window trigger for simulation waveform capture.
// Counts falling edges of an asynchronous vs after ROM download and opens a dump window.
module jtframe_frame_trig #(
    parameter int unsigned START   = 0,
    parameter int unsigned LEN     = 1,
    parameter int unsigned TIMEOUT = 1048576,
    parameter int unsigned CW      = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          vs,
    input  logic          downloading,
    output logic [CW-1:0] frame_cnt,
    output logic          dump_en,
    output logic          dump_on,
    output logic          dump_off,
    output logic          finish,
    output logic          vs_lost
);

    localparam int unsigned WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] START_V = CW'(START);
    localparam logic [WW-1:0] TIMEOUT_V = WW'(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StWait, StDump, StDone} state_t;

    state_t        state;
    logic          s1, s2, s3;
    logic          vs_fall;
    logic [CW-1:0] cnt_inc;
    logic [31:0]   win, win_inc;
    logic [WW-1:0] wd_cnt, wd_inc;

    // Decoded from flops so the FSM reacts on the third edge after the fall
    assign vs_fall = s3 & ~s2;
    assign cnt_inc = frame_cnt + 1'b1;
    assign win_inc = win + 32'd1;
    assign wd_inc  = wd_cnt + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            s3 <= 1'b1;
        end else begin
            s1 <= vs;
            s2 <= s1;
            s3 <= s2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= StIdle;
            frame_cnt <= '0;
            win       <= '0;
            dump_en   <= 1'b0;
            dump_on   <= 1'b0;
            dump_off  <= 1'b0;
            finish    <= 1'b0;
        end else begin
            dump_on  <= 1'b0;
            dump_off <= 1'b0;
            if (state != StIdle && downloading) begin
                // A new download aborts everything, closing an open window
                state     <= StIdle;
                frame_cnt <= '0;
                win       <= '0;
                finish    <= 1'b0;
                dump_en   <= 1'b0;
                if (state == StDump) dump_off <= 1'b1;
            end else begin
                case (state)
                    StIdle: begin
                        frame_cnt <= '0;
                        win       <= '0;
                        finish    <= 1'b0;
                        if (!downloading) begin
                            if (START == 0) begin
                                state   <= StDump;
                                dump_en <= 1'b1;
                                dump_on <= 1'b1;
                            end else begin
                                state <= StWait;
                            end
                        end
                    end
                    StWait: begin
                        if (vs_fall) begin
                            frame_cnt <= cnt_inc;
                            if (cnt_inc == START_V) begin
                                state   <= StDump;
                                dump_en <= 1'b1;
                                dump_on <= 1'b1;
                            end
                        end
                    end
                    StDump: begin
                        if (vs_fall) begin
                            frame_cnt <= cnt_inc;
                            win       <= win_inc;
                            if (LEN != 0 && win_inc == LEN) begin
                                state    <= StDone;
                                dump_en  <= 1'b0;
                                dump_off <= 1'b1;
                                finish   <= 1'b1;
                            end
                        end
                    end
                    StDone: begin
                        if (vs_fall) frame_cnt <= cnt_inc;
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

    // Watchdog: saturating count of clocks since the last vs fall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt  <= '0;
            vs_lost <= 1'b0;
        end else if (state == StIdle || vs_fall) begin
            wd_cnt  <= '0;
            vs_lost <= 1'b0;
        end else if (wd_cnt != TIMEOUT_V) begin
            wd_cnt  <= wd_inc;
            vs_lost <= (wd_inc == TIMEOUT_V);
        end else begin
            vs_lost <= 1'b1;
        end
    end

endmodule

// File: tb/tb_jtframe_frame_trig.sv
// Directed bench for jtframe_frame_trig: four instances with different parameter sets.
module tb_jtframe_frame_trig;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  vs_v = 4'hf;
    logic [3:0]  dl_v = 4'hf;
    logic [31:0] fc [4];
    logic [3:0]  fc3;
    logic        en [4];
    logic        on [4];
    logic        off [4];
    logic        fin [4];
    logic        lost [4];

    int checks = 0;
    int errors = 0;
    int on_cnt [4] = '{0, 0, 0, 0};
    int off_cnt [4] = '{0, 0, 0, 0};
    int on_fc [4] = '{0, 0, 0, 0};
    int off_fc [4] = '{0, 0, 0, 0};

    always #5 clk = ~clk;

    assign fc[3] = {28'd0, fc3};

    jtframe_frame_trig #(.START(3), .LEN(2), .TIMEOUT(100), .CW(32)) u_a (
        .clk(clk), .rst(rst), .vs(vs_v[0]), .downloading(dl_v[0]), .frame_cnt(fc[0]),
        .dump_en(en[0]), .dump_on(on[0]), .dump_off(off[0]), .finish(fin[0]), .vs_lost(lost[0])
    );
    jtframe_frame_trig #(.START(0), .LEN(0)) u_b (
        .clk(clk), .rst(rst), .vs(vs_v[1]), .downloading(dl_v[1]), .frame_cnt(fc[1]),
        .dump_en(en[1]), .dump_on(on[1]), .dump_off(off[1]), .finish(fin[1]), .vs_lost(lost[1])
    );
    jtframe_frame_trig #(.START(2), .LEN(4)) u_c (
        .clk(clk), .rst(rst), .vs(vs_v[2]), .downloading(dl_v[2]), .frame_cnt(fc[2]),
        .dump_en(en[2]), .dump_on(on[2]), .dump_off(off[2]), .finish(fin[2]), .vs_lost(lost[2])
    );
    jtframe_frame_trig #(.START(15), .LEN(0), .CW(4)) u_d (
        .clk(clk), .rst(rst), .vs(vs_v[3]), .downloading(dl_v[3]), .frame_cnt(fc3),
        .dump_en(en[3]), .dump_on(on[3]), .dump_off(off[3]), .finish(fin[3]), .vs_lost(lost[3])
    );

    // Pulse bookkeeping, sampled mid-cycle
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (on[k]) begin
                on_cnt[k] = on_cnt[k] + 1;
                on_fc[k]  = int'(fc[k]);
            end
            if (off[k]) begin
                off_cnt[k] = off_cnt[k] + 1;
                off_fc[k]  = int'(fc[k]);
            end
            if (on[k] && off[k]) begin
                errors = errors + 1;
                $display("FAIL on_off_overlap[%0d]: dump_on=1 dump_off=1, required not both", k);
            end
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic fall(input int k);
        vs_v[k] = 1'b0;
        repeat (5) @(posedge clk);
        #1 vs_v[k] = 1'b1;
        repeat (5) @(posedge clk);
        #1;
    endtask

    typedef struct {
        int unsigned fc;
        bit          en;
        bit          fin;
    } vec_t;

    vec_t vec_a [6];

    initial begin
        int unsigned prev;

        vec_a[0] = '{1, 1'b0, 1'b0};
        vec_a[1] = '{2, 1'b0, 1'b0};
        vec_a[2] = '{3, 1'b1, 1'b0};
        vec_a[3] = '{4, 1'b1, 1'b0};
        vec_a[4] = '{5, 1'b0, 1'b1};
        vec_a[5] = '{6, 1'b0, 1'b1};

        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rst_fc[%0d]", k), fc[k], 0);
            chk($sformatf("rst_en[%0d]", k), en[k], 0);
            chk($sformatf("rst_fin[%0d]", k), fin[k], 0);
            chk($sformatf("rst_lost[%0d]", k), lost[k], 0);
        end
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // START=3, LEN=2: table of expected state after each vs fall
        dl_v[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("a_idle_fc", fc[0], 0);
        for (int i = 0; i < 6; i++) begin
            fall(0);
            chk($sformatf("a_fc[%0d]", i), fc[0], vec_a[i].fc);
            chk($sformatf("a_en[%0d]", i), en[0], vec_a[i].en);
            chk($sformatf("a_fin[%0d]", i), fin[0], vec_a[i].fin);
        end
        chk("a_on_cnt", on_cnt[0], 1);
        chk("a_on_fc", on_fc[0], 3);
        chk("a_off_cnt", off_cnt[0], 1);
        chk("a_off_fc", off_fc[0], 5);

        // Edge latency: fall just after an edge, count changes on the third edge
        prev = fc[0];
        vs_v[0] = 1'b0;
        @(posedge clk); #1 chk("lat_edge1", fc[0], prev);
        @(posedge clk); #1 chk("lat_edge2", fc[0], prev);
        @(posedge clk); #1 chk("lat_edge3", fc[0], prev + 1);
        vs_v[0] = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // Short glitches: between edges and straddling an edge
        prev = fc[0];
        @(posedge clk); #2 vs_v[0] = 1'b0; #3 vs_v[0] = 1'b1;
        repeat (6) @(posedge clk);
        #1 chk("glitch_mid_le1", (fc[0] - prev) <= 1, 1);
        prev = fc[0];
        @(negedge clk); vs_v[0] = 1'b0; @(posedge clk); #1 vs_v[0] = 1'b1;
        repeat (6) @(posedge clk);
        #1 chk("glitch_edge_le1", (fc[0] - prev) <= 1, 1);

        // Watchdog with TIMEOUT=100 after a fresh download
        dl_v[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("wd_dl_fc", fc[0], 0);
        chk("wd_dl_fin", fin[0], 0);
        dl_v[0] = 1'b0;
        repeat (90) @(posedge clk);
        #1 chk("wd_lost_90", lost[0], 0);
        repeat (20) @(posedge clk);
        #1 chk("wd_lost_110", lost[0], 1);
        repeat (40) @(posedge clk);
        #1 chk("wd_lost_150", lost[0], 1);
        fall(0);
        chk("wd_lost_clear", lost[0], 0);
        chk("wd_fc_once", fc[0], 1);

        // START=0, LEN=0: window opens with the download release and never closes
        dl_v[1] = 1'b0;
        @(posedge clk);
        #1 chk("b_on_now", on[1], 1);
        chk("b_en_now", en[1], 1);
        for (int i = 0; i < 10; i++) begin
            fall(1);
            chk($sformatf("b_en[%0d]", i), en[1], 1);
        end
        chk("b_fc", fc[1], 10);
        chk("b_on_cnt", on_cnt[1], 1);
        chk("b_off_cnt", off_cnt[1], 0);
        chk("b_fin", fin[1], 0);

        // START=2, LEN=4: download asserted inside the window
        dl_v[2] = 1'b0;
        for (int i = 0; i < 3; i++) fall(2);
        chk("c_fc3", fc[2], 3);
        chk("c_en3", en[2], 1);
        dl_v[2] = 1'b1;
        @(posedge clk);
        #1 chk("c_abort_en", en[2], 0);
        chk("c_abort_off", off[2], 1);
        chk("c_abort_fc", fc[2], 0);
        @(posedge clk);
        #1 chk("c_off_once", off_cnt[2], 1);
        dl_v[2] = 1'b0;
        fall(2);
        chk("c_re_en1", en[2], 0);
        fall(2);
        chk("c_re_en2", en[2], 1);
        chk("c_on_cnt", on_cnt[2], 2);
        chk("c_on_fc", on_fc[2], 2);

        // CW=4, START=15, LEN=0: counter wraps without reopening
        dl_v[3] = 1'b0;
        for (int i = 0; i < 17; i++) begin
            fall(3);
            if (i == 14) chk("d_en_at15", en[3], 1);
        end
        chk("d_fc_wrap", fc[3], 1);
        chk("d_on_cnt", on_cnt[3], 1);
        chk("d_on_fc", on_fc[3], 15);
        chk("d_en_end", en[3], 1);
        chk("d_off_cnt", off_cnt[3], 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
